timer_bank: RTL
===============

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent counter channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 4: counter width in bits per channel (2..32).
REQ-003 SHALL have parameter EN_ACT, default 1: active level of cnt_en bits.
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cnt_en  input  NUM_CH  per-channel count enable; active when bit equals EN_ACT.
REQ-007 SHALL have port cnt_clr  input  NUM_CH  per-channel synchronous clear, active-high.
REQ-008 SHALL have port hold_mode  input  NUM_CH  1 = hold value when disabled; 0 = clear to zero when disabled.
REQ-009 SHALL have port sat_mode  input  NUM_CH  1 = saturate at all-ones; 0 = wrap to zero.
REQ-010 SHALL have port term_val  input  NUM_CH*CNT_W  per-channel terminal value; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port cnt_out  output  NUM_CH*CNT_W  registered count values, same packing as term_val.
REQ-012 SHALL have port term_hit  output  NUM_CH  level: cnt_out slice equals term_val slice (combinational compare of registered count).
REQ-013 SHALL have port term_pulse  output  NUM_CH  registered one-cycle pulse when an increment lands on term_val.
REQ-014 SHALL have port ovf  output  NUM_CH  registered sticky overflow flag.

Function
REQ-015 SHALL evaluate each channel independently every rising clk edge with priority: cnt_clr > enable active > enable inactive.
REQ-016 SHALL, on cnt_clr=1, load count 0, clear ovf, and drive term_pulse 0 next cycle, regardless of cnt_en.
REQ-017 SHALL, with enable active and count < all-ones, load count+1 (modulo 2^CNT_W), latency one cycle.
REQ-018 SHALL, with enable active, count = all-ones and sat_mode=0, load 0 and set ovf.
REQ-019 SHALL, with enable active, count = all-ones and sat_mode=1, hold all-ones and set ovf.
REQ-020 SHALL, with enable inactive, hold count if hold_mode=1, else load 0; ovf unchanged in both cases.
REQ-021 SHALL assert term_pulse in exactly the cycle cnt_out first shows an incremented value equal to term_val; saturated holds, disabled holds, clears and reset SHALL NOT pulse.
REQ-022 SHALL, with term_val=0 and sat_mode=0, pulse term_pulse on the wrap from all-ones to 0.
REQ-023 SHALL apply mode and term_val input changes on the next evaluating edge; no internal latching of these inputs.
REQ-024 SHALL keep ovf set until cnt_clr or rst; a new overflow while set leaves it set.

Reset
REQ-025 SHALL, while rst=1, force every cnt_out slice, term_pulse and ovf to 0 asynchronously.
REQ-026 SHALL, on rst mid-count, discard the count; first edge after release evaluates per REQ-015 from count 0.
REQ-027 SHALL output term_hit = 1 during reset for any channel whose term_val is 0.

Structure
REQ-028 SHALL place enable-level constants (enable/disable encodings replacing per-counter defines) and mode-bit encodings (HOLD/CLEAR, SAT/WRAP) in shared package timer_pkg.
REQ-029 SHALL implement one channel as sub-module timer_chan, instantiated NUM_CH times via generate.
REQ-030 SHALL contain no cross-channel logic; channels share only clk and rst.

Verification
REQ-031 SHALL test wrap: CNT_W=4, sat_mode=0, enable held 17 cycles from 0 -> cnt_out reaches 15, then 0, then 1; ovf rises with the 0 and stays set.
REQ-032 SHALL test saturate: sat_mode=1, enable 20 cycles -> cnt_out sticks at 15, ovf=1, no term_pulse while held at 15 with term_val=15 after the first pulse.
REQ-033 SHALL test modes: count to 5, drop enable -> hold_mode=1 keeps 5; hold_mode=0 gives 0 next cycle; ovf unchanged.
REQ-034 SHALL test terminal: term_val=7, enable from 0 -> term_pulse exactly once, cycle cnt_out=7; term_hit high while cnt_out=7.
REQ-035 SHALL test priority: cnt_clr and enable both 1 at count 9 with ovf=1 -> count 0, ovf 0 next cycle.
REQ-036 SHALL test reset mid-operation: rst asserted asynchronously at count 6 on all 3 channels -> all outputs 0 immediately; after release counting restarts 1, 2, 3.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer bank: enable-level encodings,
// mode-bit encodings and the per-channel action decode.
package timer_pkg;

  // Enable-level encodings used for the EN_ACT parameter.
  localparam logic EN_ACTIVE_HIGH = 1'b1;
  localparam logic EN_ACTIVE_LOW  = 1'b0;

  // hold_mode encodings.
  localparam logic MODE_HOLD  = 1'b1;
  localparam logic MODE_CLEAR = 1'b0;

  // sat_mode encodings.
  localparam logic MODE_SAT  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;

  // What a channel does on the next edge; clear outranks enable.
  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_IDLE  = 2'd2
  } chan_act_e;

  function automatic chan_act_e chan_action(input logic clr, input logic en_active);
    if (clr)            return ACT_CLEAR;
    else if (en_active) return ACT_COUNT;
    else                return ACT_IDLE;
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One counter channel of the timer bank.
// Ports: clk, rst (async, active-high); en_active (already level-decoded),
// clr, hold_mode, sat_mode, term_val in; cnt, term_hit (combinational),
// term_pulse, ovf out.
module timer_chan
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_active,
  input  logic             clr,
  input  logic             hold_mode,
  input  logic             sat_mode,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             term_hit,
  output logic             term_pulse,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;

  // Next-state decode for count, sticky overflow and terminal pulse.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    at_max  = (cnt_q == {CNT_W{1'b1}});
    case (chan_action(clr, en_active))
      ACT_CLEAR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      ACT_COUNT: begin
        if (!at_max) begin
          cnt_d   = cnt_inc;
          pulse_d = (cnt_inc == term_val);
        end else begin
          ovf_d = 1'b1;
          // A saturated hold is not an increment, so it never pulses.
          if (sat_mode == MODE_WRAP) begin
            cnt_d   = '0;
            pulse_d = (term_val == '0);
          end
        end
      end
      default: begin
        if (hold_mode == MODE_CLEAR) cnt_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
    end
  end

  assign cnt        = cnt_q;
  assign ovf        = ovf_q;
  assign term_pulse = pulse_q;
  // Compare of the registered count; reads 1 in reset when term_val is 0.
  assign term_hit   = (cnt_q == term_val);

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent counter channels.
// Ports: clk, rst (async, active-high); cnt_en, cnt_clr, hold_mode,
// sat_mode (one bit per channel); term_val / cnt_out packed CNT_W per
// channel; term_hit (combinational), term_pulse, ovf per channel.
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 4,
  parameter logic        EN_ACT = EN_ACTIVE_HIGH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       cnt_en,
  input  logic [NUM_CH-1:0]       cnt_clr,
  input  logic [NUM_CH-1:0]       hold_mode,
  input  logic [NUM_CH-1:0]       sat_mode,
  input  logic [NUM_CH*CNT_W-1:0] term_val,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic [NUM_CH-1:0]       term_hit,
  output logic [NUM_CH-1:0]       term_pulse,
  output logic [NUM_CH-1:0]       ovf
);

  // Channels are fully independent; only clk and rst are shared.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
    timer_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_active (cnt_en[i] == EN_ACT),
      .clr       (cnt_clr[i]),
      .hold_mode (hold_mode[i]),
      .sat_mode  (sat_mode[i]),
      .term_val  (term_val[i*CNT_W +: CNT_W]),
      .cnt       (cnt_out[i*CNT_W +: CNT_W]),
      .term_hit  (term_hit[i]),
      .term_pulse(term_pulse[i]),
      .ovf       (ovf[i])
    );
  end

endmodule
